multi_byte_add_sequencer: RTL

MULTI_BYTE_ADD_SEQUENCER -- requirements
Module: multi_byte_add_sequencer

---
 rtl/multi_byte_add_sequencer.sv | 99 +++++++++
 1 files changed

// File: rtl/multi_byte_add_sequencer.sv
// rtl/multi_byte_add_sequencer.sv - 32-bit add/sub sequenced byte-wise through an external 8-bit adder
module multi_byte_add_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_sum,
    input  logic        add_cout,
    output logic [31:0] result,
    output logic        carry,
    output logic        ovf,
    output logic        out_valid,
    input  logic        out_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] a_q;
    logic [31:0] b_q;   // op_b already inverted for subtraction
    logic [1:0]  idx;
    logic        c;

    // Sequencer: accept operands, walk bytes 0..3 through the adder, hold result until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            idx       <= 2'd0;
            c         <= 1'b0;
            result    <= 32'd0;
            carry     <= 1'b0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q      <= op_a;
                        b_q      <= op_b ^ {32{sub}};
                        idx      <= 2'd0;
                        c        <= sub;   // +1 of the two's-complement negate
                        in_ready <= 1'b0;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    result[{idx, 3'b000} +: 8] <= add_sum;
                    c   <= add_cout;
                    idx <= idx + 2'd1;
                    if (idx == 2'd3) begin
                        carry     <= add_cout;
                        ovf       <= (a_q[31] == b_q[31]) && (add_sum[7] != a_q[31]);
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    // Returning to IDLE never overlaps with a new acceptance
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

    // Adder operand steering: current byte while running, quiet zeros otherwise
    always_comb begin
        add_a   = 8'd0;
        add_b   = 8'd0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[{idx, 3'b000} +: 8];
            add_b   = b_q[{idx, 3'b000} +: 8];
            add_cin = c;
        end
    end

endmodule
